reg_writeback: RTL and testbench

- Writer-side front end for the 16x16 register file: accepts completed results from the ALU and memory pipelines and buffers them in a small in-order FIFO.
- Drains the FIFO into the register file's single write port (DstReg/DstData/WriteReg) at one write per cycle.
- Reports per-register pending-write status to decode so reads of not-yet-written registers can be stalled.

---
 rtl/wb_pkg.sv | 17 +
 rtl/wb_fifo.sv | 89 ++++++++
 rtl/reg_writeback.sv | 90 +++++++++
 tb/tb_reg_writeback.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback front end.
package wb_pkg;

  localparam int REG_W  = 4;
  localparam int DATA_W = 16;

  typedef struct packed {
    logic [REG_W-1:0]  dst;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // Register 0 is hardwired zero, so writes to it are dropped and never pending.
  function automatic logic is_zero_reg(input logic [REG_W-1:0] r);
    return (r == {REG_W{1'b0}});
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order write buffer: head read combinationally from storage, with per-entry
// valid bits and destination fields exposed for the pending-register compare.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push_i,
  input  wb_entry_t                   wr_entry_i,
  input  logic                        pop_i,
  input  logic                        flush_i,
  output wb_entry_t                   head_o,
  output logic [AW-1:0]               rd_ptr_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [DEPTH-1:0]            valid_o,
  output logic [DEPTH-1:0][REG_W-1:0] regs_o
);

  wb_entry_t       mem_q [DEPTH];
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            do_push, do_pop;
  logic [AW-1:0]   offset;

  assign full_o   = (count_q == (AW+1)'(DEPTH));
  assign empty_o  = (count_q == {(AW+1){1'b0}});
  assign do_push  = push_i && !full_o;
  assign do_pop   = pop_i && !empty_o;
  assign head_o   = mem_q[rd_ptr_q];
  assign rd_ptr_o = rd_ptr_q;

  // Pointer and occupancy next-state; flush wins over any push or pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = {AW{1'b0}};
      wr_ptr_d = {AW{1'b0}};
      count_d  = {(AW+1){1'b0}};
    end else begin
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      else        rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      else         wr_ptr_d = wr_ptr_q;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Slot i is occupied when its distance from the read pointer is below count.
  always_comb begin
    valid_o = {DEPTH{1'b0}};
    regs_o  = '0;
    offset  = {AW{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      offset     = AW'(i) - rd_ptr_q;
      valid_o[i] = ({1'b0, offset} < count_q);
      regs_o[i]  = mem_q[i].dst;
    end
  end

  // Pointer and count state.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= {AW{1'b0}};
      wr_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are qualified by valid_o so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wr_entry_i;
  end

endmodule

// File: rtl/reg_writeback.sv
// Writeback front end: arbitrates ALU/memory results into an in-order buffer,
// drains it into the register-file write port and reports pending writes.
module reg_writeback
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [REG_W-1:0]  alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [REG_W-1:0]  mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              wb_stall,
  input  logic              flush,
  input  logic [REG_W-1:0]  SrcReg1,
  input  logic [REG_W-1:0]  SrcReg2,
  output logic              Pending1,
  output logic              Pending2,
  output logic [REG_W-1:0]  DstReg,
  output logic [DATA_W-1:0] DstData,
  output logic              WriteReg,
  output logic              full,
  output logic              empty
);

  wb_entry_t                   in_entry, head;
  logic                        push;
  logic [AW-1:0]               rd_ptr;
  logic [DEPTH-1:0]            valid;
  logic [DEPTH-1:0]            live;
  logic [DEPTH-1:0][REG_W-1:0] regs;
  logic                        pend1, pend2;

  // Readiness looks only at registered occupancy; a same-cycle drain frees nothing.
  assign mem_ready = !full && !flush;
  assign alu_ready = !full && !flush && !mem_valid;
  assign WriteReg  = !empty && !wb_stall;
  assign DstReg    = WriteReg ? head.dst  : {REG_W{1'b0}};
  assign DstData   = WriteReg ? head.data : {DATA_W{1'b0}};

  // Memory has fixed priority; results for R0 are acknowledged but dropped.
  always_comb begin
    if (mem_valid && mem_ready) begin
      in_entry = '{dst: mem_reg, data: mem_data};
      push     = !is_zero_reg(mem_reg);
    end else if (alu_valid && alu_ready) begin
      in_entry = '{dst: alu_reg, data: alu_data};
      push     = !is_zero_reg(alu_reg);
    end else begin
      in_entry = '{dst: {REG_W{1'b0}}, data: {DATA_W{1'b0}}};
      push     = 1'b0;
    end
  end

  // The entry being written this cycle is excluded: the register file bypasses it.
  always_comb begin
    pend1 = 1'b0;
    pend2 = 1'b0;
    live  = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      live[i] = valid[i] && !(WriteReg && (rd_ptr == AW'(i)));
      pend1   = pend1 | (live[i] && (regs[i] == SrcReg1));
      pend2   = pend2 | (live[i] && (regs[i] == SrcReg2));
    end
    Pending1 = pend1 && !is_zero_reg(SrcReg1);
    Pending2 = pend2 && !is_zero_reg(SrcReg2);
  end

  wb_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .wr_entry_i (in_entry),
    .pop_i      (WriteReg),
    .flush_i    (flush),
    .head_o     (head),
    .rd_ptr_o   (rd_ptr),
    .full_o     (full),
    .empty_o    (empty),
    .valid_o    (valid),
    .regs_o     (regs)
  );

endmodule

// File: tb/tb_reg_writeback.sv
// Directed vector table plus randomized traffic checked against a queue model.
module tb_reg_writeback;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, alu_valid, mem_valid, wb_stall, flush;
  logic [3:0]  alu_reg, mem_reg, SrcReg1, SrcReg2, DstReg;
  logic [15:0] alu_data, mem_data, DstData;
  logic        alu_ready, mem_ready, Pending1, Pending2, WriteReg, full, empty;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit rst; bit av; bit [3:0] ar; bit [15:0] ad;
    bit mv; bit [3:0] mr; bit [15:0] md;
    bit st; bit fl; bit [3:0] s1; bit [3:0] s2;
    bit wr; bit [3:0] dr; bit [15:0] dd;
    bit ardy; bit mrdy; bit p1; bit p2; bit emp; bit ful;
  } vec_t;

  typedef struct { bit [3:0] r; bit [15:0] d; } ent_t;

  ent_t mq[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  reg_writeback #(.DEPTH(DEPTH), .AW(2)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
    .wb_stall(wb_stall), .flush(flush), .SrcReg1(SrcReg1), .SrcReg2(SrcReg2),
    .Pending1(Pending1), .Pending2(Pending2), .DstReg(DstReg), .DstData(DstData),
    .WriteReg(WriteReg), .full(full), .empty(empty)
  );

  task automatic chk(input string nm, input int row, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %h, expected %h", nm, row, act, exp);
    end
  endtask

  function automatic bit model_pending(input bit [3:0] s, input bit skip_head);
    if (s == 4'd0) return 1'b0;
    for (int j = (skip_head ? 1 : 0); j < mq.size(); j++)
      if (mq[j].r == s) return 1'b1;
    return 1'b0;
  endfunction

  // Drive one cycle (called at negedge), check outputs, then advance the model.
  task automatic apply(input vec_t v, input bit use_model, input int row);
    vec_t e;
    bit   m_wr, m_full;
    e = v;
    rst = v.rst; alu_valid = v.av; alu_reg = v.ar; alu_data = v.ad;
    mem_valid = v.mv; mem_reg = v.mr; mem_data = v.md;
    wb_stall = v.st; flush = v.fl; SrcReg1 = v.s1; SrcReg2 = v.s2;
    #1;
    m_full = (mq.size() == DEPTH);
    m_wr   = (mq.size() != 0) && !v.st;
    if (use_model) begin
      e.wr   = m_wr;
      e.dr   = m_wr ? mq[0].r : 4'd0;
      e.dd   = m_wr ? mq[0].d : 16'd0;
      e.mrdy = !m_full && !v.fl;
      e.ardy = !m_full && !v.fl && !v.mv;
      e.p1   = model_pending(v.s1, m_wr);
      e.p2   = model_pending(v.s2, m_wr);
      e.emp  = (mq.size() == 0);
      e.ful  = m_full;
    end
    chk("WriteReg",  row, {15'd0, WriteReg},  {15'd0, e.wr});
    chk("DstReg",    row, {12'd0, DstReg},    {12'd0, e.dr});
    chk("DstData",   row, DstData,            e.dd);
    chk("alu_ready", row, {15'd0, alu_ready}, {15'd0, e.ardy});
    chk("mem_ready", row, {15'd0, mem_ready}, {15'd0, e.mrdy});
    chk("Pending1",  row, {15'd0, Pending1},  {15'd0, e.p1});
    chk("Pending2",  row, {15'd0, Pending2},  {15'd0, e.p2});
    chk("empty",     row, {15'd0, empty},     {15'd0, e.emp});
    chk("full",      row, {15'd0, full},      {15'd0, e.ful});
    @(posedge clk);
    if (v.rst) begin
      mq.delete();
    end else begin
      if (m_wr) void'(mq.pop_front());
      if (v.fl) mq.delete();
      else if (!m_full) begin
        if (v.mv) begin
          if (v.mr != 4'd0) mq.push_back('{r: v.mr, d: v.md});
        end else if (v.av && v.ar != 4'd0) begin
          mq.push_back('{r: v.ar, d: v.ad});
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    vec_t v;
    // rst av ar ad | mv mr md | st fl s1 s2 | wr dr dd | ardy mrdy p1 p2 emp ful
    tbl.push_back('{0,0,0,16'h0000, 0,0,16'h0000, 0,0,0,0, 0,0,16'h0000, 1,1,0,0,1,0});
    tbl.push_back('{0,1,3,16'h1234, 0,0,16'h0000, 0,0,3,0, 0,0,16'h0000, 1,1,0,0,1,0});
    tbl.push_back('{0,0,0,16'h0000, 0,0,16'h0000, 0,0,3,0, 1,3,16'h1234, 1,1,0,0,0,0});
    tbl.push_back('{0,0,0,16'h0000, 0,0,16'h0000, 0,0,0,0, 0,0,16'h0000, 1,1,0,0,1,0});
    tbl.push_back('{0,1,6,16'h5555, 1,5,16'hAAAA, 0,0,0,0, 0,0,16'h0000, 0,1,0,0,1,0});
    tbl.push_back('{0,1,6,16'h5555, 0,0,16'h0000, 0,0,5,6, 1,5,16'hAAAA, 1,1,0,0,0,0});
    tbl.push_back('{0,0,0,16'h0000, 0,0,16'h0000, 0,0,6,0, 1,6,16'h5555, 1,1,0,0,0,0});
    tbl.push_back('{0,1,1,16'h0101, 0,0,16'h0000, 1,0,0,0, 0,0,16'h0000, 1,1,0,0,1,0});
    tbl.push_back('{0,1,2,16'h0202, 0,0,16'h0000, 1,0,1,0, 0,0,16'h0000, 1,1,1,0,0,0});
    tbl.push_back('{0,1,3,16'h0303, 0,0,16'h0000, 1,0,2,0, 0,0,16'h0000, 1,1,1,0,0,0});
    tbl.push_back('{0,1,4,16'h0404, 0,0,16'h0000, 1,0,3,4, 0,0,16'h0000, 1,1,1,0,0,0});
    tbl.push_back('{0,1,5,16'h0505, 0,0,16'h0000, 1,0,2,5, 0,0,16'h0000, 0,0,1,0,0,1});
    tbl.push_back('{0,1,5,16'h0505, 0,0,16'h0000, 0,0,1,4, 1,1,16'h0101, 0,0,0,1,0,1});
    tbl.push_back('{0,1,5,16'h0505, 0,0,16'h0000, 0,0,0,0, 1,2,16'h0202, 1,1,0,0,0,0});
    tbl.push_back('{0,0,0,16'h0000, 0,0,16'h0000, 0,0,5,0, 1,3,16'h0303, 1,1,1,0,0,0});
    tbl.push_back('{0,0,0,16'h0000, 0,0,16'h0000, 0,0,0,0, 1,4,16'h0404, 1,1,0,0,0,0});
    tbl.push_back('{0,0,0,16'h0000, 0,0,16'h0000, 0,0,5,0, 1,5,16'h0505, 1,1,0,0,0,0});
    tbl.push_back('{0,1,0,16'hFFFF, 0,0,16'h0000, 0,0,0,0, 0,0,16'h0000, 1,1,0,0,1,0});
    tbl.push_back('{0,0,0,16'h0000, 0,0,16'h0000, 0,0,0,0, 0,0,16'h0000, 1,1,0,0,1,0});
    tbl.push_back('{0,1,7,16'h0707, 0,0,16'h0000, 1,0,0,0, 0,0,16'h0000, 1,1,0,0,1,0});
    tbl.push_back('{0,1,8,16'h0808, 0,0,16'h0000, 1,0,0,0, 0,0,16'h0000, 1,1,0,0,0,0});
    tbl.push_back('{0,1,9,16'h0909, 0,0,16'h0000, 1,0,0,0, 0,0,16'h0000, 1,1,0,0,0,0});
    tbl.push_back('{0,1,10,16'h0A0A, 0,0,16'h0000, 0,1,8,9, 1,7,16'h0707, 0,0,1,1,0,0});
    tbl.push_back('{0,0,0,16'h0000, 0,0,16'h0000, 0,0,8,9, 0,0,16'h0000, 1,1,0,0,1,0});
    tbl.push_back('{0,1,11,16'h0B0B, 0,0,16'h0000, 1,0,0,0, 0,0,16'h0000, 1,1,0,0,1,0});
    tbl.push_back('{0,1,12,16'h0C0C, 0,0,16'h0000, 1,0,0,0, 0,0,16'h0000, 1,1,0,0,0,0});
    tbl.push_back('{1,0,0,16'h0000, 0,0,16'h0000, 1,0,11,0, 0,0,16'h0000, 1,1,1,0,0,0});
    tbl.push_back('{0,0,0,16'h0000, 0,0,16'h0000, 0,0,11,0, 0,0,16'h0000, 1,1,0,0,1,0});
    tbl.push_back('{0,1,13,16'h0D0D, 0,0,16'h0000, 0,0,0,0, 0,0,16'h0000, 1,1,0,0,1,0});
    tbl.push_back('{0,0,0,16'h0000, 0,0,16'h0000, 0,0,13,0, 1,13,16'h0D0D, 1,1,0,0,0,0});
    tbl.push_back('{0,0,0,16'h0000, 0,0,16'h0000, 0,0,0,0, 0,0,16'h0000, 1,1,0,0,1,0});

    rst = 1'b1; alu_valid = 1'b0; alu_reg = 4'd0; alu_data = 16'd0;
    mem_valid = 1'b0; mem_reg = 4'd0; mem_data = 16'd0;
    wb_stall = 1'b0; flush = 1'b0; SrcReg1 = 4'd0; SrcReg2 = 4'd0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    mq.delete();

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], 1'b0, i);

    for (int i = 0; i < 600; i++) begin
      v.rst = ($urandom_range(0, 59) == 0);
      v.av  = $urandom_range(0, 1) == 1;
      v.ar  = 4'($urandom_range(0, 15));
      v.ad  = 16'($urandom);
      v.mv  = $urandom_range(0, 2) == 0;
      v.mr  = 4'($urandom_range(0, 15));
      v.md  = 16'($urandom);
      v.st  = $urandom_range(0, 2) == 0;
      v.fl  = ($urandom_range(0, 24) == 0);
      v.s1  = 4'($urandom_range(0, 15));
      v.s2  = 4'($urandom_range(0, 15));
      apply(v, 1'b1, 1000 + i);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
